// File: rtl/rr_onehot_arbiter.sv
// ============================================================================
// Module   : rr_onehot_arbiter
// Purpose  : Round-robin arbiter with a registered one-hot grant and a hold limit.
//            Optional one-hot self-checker enabled by macro ONEHOT_CHECK_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_onehot_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       done,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       gnt_valid,
  output logic [$clog2(NUM_REQ)-1:0] gnt_id,
  output logic                       preempt,
  output logic                       onehot_err
);

  localparam int c_ID_W   = $clog2(NUM_REQ);
  localparam int c_HOLD_W = $clog2(MAX_HOLD + 1);
  localparam int c_CNT_W  = $clog2(NUM_REQ + 1);

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_GRANT = 1'b1;

  logic [0:0]          r_state;
  logic [c_ID_W-1:0]   r_ptr;
  logic [c_HOLD_W-1:0] r_hold_cnt;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [c_ID_W-1:0]   r_gnt_id;
  logic                r_preempt;

  logic [c_ID_W-1:0]   w_win_id;
  logic [c_ID_W-1:0]   w_next_ptr;
  logic                w_owner_req;
  logic                w_limit;
  logic                w_release;

  // Scan from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    int idx;
    w_win_id = '0;
    idx      = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = int'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req[idx]) w_win_id = c_ID_W'(idx);
    end
  end

  assign w_owner_req = req[r_gnt_id];
  assign w_limit     = (r_hold_cnt == c_HOLD_W'(MAX_HOLD - 1));
  assign w_release   = done | ~w_owner_req | w_limit;
  assign w_next_ptr  = (r_gnt_id == c_ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + c_ID_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= c_ST_IDLE;
      r_ptr      <= '0;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_preempt  <= 1'b0;
    end else begin
      r_preempt <= 1'b0;
      case (r_state)
        c_ST_IDLE: begin
          r_hold_cnt <= '0;
          if (|req) begin
            r_state  <= c_ST_GRANT;
            r_gnt    <= NUM_REQ'(1) << w_win_id;
            r_gnt_id <= w_win_id;
          end
        end
        c_ST_GRANT: begin
          if (w_release) begin
            r_state    <= c_ST_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= '0;
            r_ptr      <= w_next_ptr;
            r_hold_cnt <= '0;
            // Only a pure timeout is a preemption; a voluntary release wins a tie.
            r_preempt  <= w_limit & ~done & w_owner_req;
          end else begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
          end
        end
        default: begin
          r_state <= c_ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = |r_gnt;
  assign gnt_id    = r_gnt_id;
  assign preempt   = r_preempt;

`ifdef ONEHOT_CHECK_EN
  logic [c_CNT_W-1:0] w_popcnt;
  logic               r_onehot_err;

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_popcnt = w_popcnt + c_CNT_W'(r_gnt[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_onehot_err <= 1'b0;
    end else if ((w_popcnt > c_CNT_W'(1)) || (gnt_valid && (w_popcnt != c_CNT_W'(1)))) begin
      r_onehot_err <= 1'b1;
    end
  end

  assign onehot_err = r_onehot_err;
`else
  assign onehot_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_rr_onehot_arbiter.sv
// ============================================================================
// Module   : tb_rr_onehot_arbiter
// Purpose  : Directed vector bench for rr_onehot_arbiter (NUM_REQ=4, MAX_HOLD=8).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_onehot_arbiter;

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  logic       clk;
  logic       reset;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic       gnt_valid;
  logic [1:0] gnt_id;
  logic       preempt;
  logic       onehot_err;

  int n_checks;
  int n_errors;
  vec_t vecs[$];

  rr_onehot_arbiter #(.NUM_REQ(4), .MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .preempt   (preempt),
    .onehot_err(onehot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic [3:0] r, input logic d, input logic [3:0] g,
                              input logic [1:0] id, input logic p);
    vec_t v;
    v.req = r; v.done = d; v.gnt = g; v.id = id; v.pre = p;
    vecs.push_back(v);
  endfunction

  // Compares {gnt, gnt_valid, gnt_id, preempt, onehot_err} against expectations.
  task automatic check(input string name, input logic [3:0] eg, input logic [1:0] eid,
                       input logic ep, input logic eerr);
    logic [8:0] got, exp;
    got = {gnt, gnt_valid, gnt_id, preempt, onehot_err};
    exp = {eg, (eg != 4'b0000), eid, ep, eerr};
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got gnt=%b valid=%b id=%0d pre=%b err=%b, want gnt=%b valid=%b id=%0d pre=%b err=%b",
               name, gnt, gnt_valid, gnt_id, preempt, onehot_err,
               eg, (eg != 4'b0000), eid, ep, eerr);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;

    // Rotation with req all-ones, done on each grant's second cycle.
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b0010, 1, 0);
    add(4'b1111, 0, 4'b0010, 1, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b0100, 2, 0);
    add(4'b1111, 0, 4'b0100, 2, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b1000, 3, 0);
    add(4'b1111, 0, 4'b1000, 3, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    add(4'b1111, 0, 4'b0001, 0, 0);
    add(4'b1111, 1, 4'b0000, 0, 0);
    // Pointer now 1: search skips to 3, then wraps to 0.
    add(4'b1001, 0, 4'b1000, 3, 0);
    add(4'b1001, 1, 4'b0000, 0, 0);
    add(4'b1001, 0, 4'b0001, 0, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);
    add(4'b0000, 1, 4'b0000, 0, 0);
    // Hold limit: eight grant cycles, preempt, then re-grant.
    for (int i = 0; i < 8; i++) add(4'b0010, 0, 4'b0010, 1, 0);
    add(4'b0010, 0, 4'b0000, 0, 1);
    add(4'b0010, 0, 4'b0010, 1, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);
    // Release by request drop.
    add(4'b1000, 0, 4'b1000, 3, 0);
    add(4'b1000, 0, 4'b1000, 3, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);
    // done coinciding with the hold limit is a normal release.
    for (int i = 0; i < 8; i++) add(4'b0001, 0, 4'b0001, 0, 0);
    add(4'b0001, 1, 4'b0000, 0, 0);
    add(4'b0000, 0, 4'b0000, 0, 0);

    step();
    check("reset_state", 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      done = vecs[i].done;
      step();
      check($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].id, vecs[i].pre, 1'b0);
    end
    done = 1'b0;

    // Reset asserted mid-grant drops gnt without a clock edge.
    req = 4'b0100;
    step();
    check("grant_before_reset", 4'b0100, 2'd2, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    check("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
    #2 reset = 1'b0;
    step();
    check("grant_after_reset", 4'b0100, 2'd2, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    check("release_after_reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    // Pointer is 3 here; reset must return the search start to 0.
    #2 reset = 1'b1;
    #2 reset = 1'b0;
    req = 4'b1001;
    step();
    check("ptr_reset_to_zero", 4'b0001, 2'd0, 1'b0, 1'b0);
    req = 4'b0000;
    step();
    check("idle_before_checker", 4'b0000, 2'd0, 1'b0, 1'b0);

`ifdef ONEHOT_CHECK_EN
    force dut.r_gnt = 4'b0110;
    step();
    release dut.r_gnt;
    #2 reset = 1'b0;
    n_checks++;
    if (onehot_err !== 1'b1) begin
      n_errors++;
      $display("FAIL onehot_err_set: got %b want 1", onehot_err);
    end
    step();
    step();
    n_checks++;
    if (onehot_err !== 1'b1) begin
      n_errors++;
      $display("FAIL onehot_err_sticky: got %b want 1", onehot_err);
    end
    reset = 1'b1;
    #1;
    reset = 1'b0;
    step();
    check("onehot_err_cleared", 4'b0000, 2'd0, 1'b0, 1'b0);
`else
    repeat (3) step();
    check("onehot_err_tied_low", 4'b0000, 2'd0, 1'b0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
